// File: rtl/melody_player_if.sv
// Control-side bundle for melody_player: start/select/stop requests in,
// buzzer drive and playback status out.
interface melody_player_if;
   logic       start;
   logic [2:0] sel;
   logic       stop;
   logic       sound;
   logic       busy;
   logic       done;
   logic [2:0] note_idx;
   logic [3:0] step;

   modport master (output start, sel, stop, input sound, busy, done, note_idx, step);
   modport slave  (input start, sel, stop, output sound, busy, done, note_idx, step);
endinterface

// File: rtl/melody_player.sv
// Tone sequencer for the passive buzzer: plays one of five fixed melodies as
// 50%-duty square-wave notes with optional silent gaps between them.
module melody_player #(
   parameter int NOTE_CYCLES  = 12500000,
   parameter int GAP_CYCLES   = 1250000,
   parameter int OCTAVE_SHIFT = 0
) (
   input  logic           CLOCK_50,
   input  logic           resetn,
   melody_player_if.slave bus
);
   localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

   state_t      state;
   logic [2:0]  mel;
   logic [3:0]  step_r;
   logic [2:0]  note_r;
   logic        sound_r;
   logic        busy_r;
   logic        done_r;
   logic [16:0] half_cnt;
   logic [31:0] dur_cnt;
   logic [16:0] half_last;
   logic        last_step;
   logic        note_end;
   logic        seq_end;

   function automatic logic [16:0] half_period(input logic [2:0] n);
      logic [16:0] base;
      case (n)
         3'd0:    base = 17'd56818;
         3'd1:    base = 17'd50607;
         3'd2:    base = 17'd47801;
         3'd3:    base = 17'd42589;
         3'd4:    base = 17'd37936;
         3'd5:    base = 17'd35816;
         default: base = 17'd31887;
      endcase
      return base >> OCTAVE_SHIFT;
   endfunction

   function automatic logic [2:0] rom_note(input logic [2:0] m, input logic [3:0] s);
      logic [2:0] n;
      n = 3'd0;
      case (m)
         3'd0: case (s)
                  4'd0: n = 3'd2;  4'd1: n = 3'd6;  4'd2: n = 3'd3;
                  4'd3: n = 3'd5;  4'd4: n = 3'd4;  4'd5: n = 3'd2;
                  default: n = 3'd0;
               endcase
         3'd1: case (s)
                  4'd0, 4'd1, 4'd3: n = 3'd2;
                  4'd2:             n = 3'd4;
                  default:          n = 3'd6;
               endcase
         3'd2: n = (s == 4'd0) ? 3'd4 : 3'd6;
         3'd3: n = (s == 4'd0) ? 3'd1 : 3'd0;
         3'd4: case (s)
                  4'd0: n = 3'd5;  4'd1: n = 3'd3;  4'd2: n = 3'd2;
                  default: n = 3'd0;
               endcase
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] mel_last(input logic [2:0] m);
      case (m)
         3'd0:    return 4'd5;
         3'd1:    return 4'd7;
         3'd4:    return 4'd3;
         default: return 4'd1;
      endcase
   endfunction

   // seq_end marks the cycle a note slot (tone plus any gap) is complete.
   always_comb begin
      half_last = half_period(note_r) - 17'd1;
      last_step = (step_r == mel_last(mel));
      note_end  = (state == TONE) && (dur_cnt == NOTE_LAST);
      seq_end   = (note_end && !HAS_GAP) || ((state == GAP) && (dur_cnt == GAP_LAST));
   end

   // Stop and natural completion share the return path; only completion pulses done.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state    <= IDLE;
         mel      <= 3'd0;
         step_r   <= 4'd0;
         note_r   <= 3'd0;
         sound_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         half_cnt <= 17'd0;
         dur_cnt  <= 32'd0;
      end else begin
         done_r <= 1'b0;
         if (state == IDLE) begin
            if (bus.start && !bus.stop && (bus.sel <= 3'd4)) begin
               state    <= TONE;
               mel      <= bus.sel;
               step_r   <= 4'd0;
               note_r   <= rom_note(bus.sel, 4'd0);
               busy_r   <= 1'b1;
               sound_r  <= 1'b0;
               half_cnt <= 17'd0;
               dur_cnt  <= 32'd0;
            end
         end else if (bus.stop || (seq_end && last_step)) begin
            state    <= IDLE;
            step_r   <= 4'd0;
            note_r   <= 3'd0;
            sound_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= !bus.stop;
            half_cnt <= 17'd0;
            dur_cnt  <= 32'd0;
         end else if (seq_end) begin
            state    <= TONE;
            step_r   <= step_r + 4'd1;
            note_r   <= rom_note(mel, step_r + 4'd1);
            sound_r  <= 1'b0;
            half_cnt <= 17'd0;
            dur_cnt  <= 32'd0;
         end else if (note_end) begin
            state    <= GAP;
            note_r   <= 3'd0;
            sound_r  <= 1'b0;
            half_cnt <= 17'd0;
            dur_cnt  <= 32'd0;
         end else begin
            dur_cnt <= dur_cnt + 32'd1;
            if (state == TONE) begin
               if (half_cnt == half_last) begin
                  half_cnt <= 17'd0;
                  sound_r  <= ~sound_r;
               end else begin
                  half_cnt <= half_cnt + 17'd1;
               end
            end
         end
      end
   end

   assign bus.sound    = sound_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.note_idx = note_r;
   assign bus.step     = step_r;
endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: three parameterisations checked every cycle against
// a model that derives outputs from elapsed time since the accepted start.
module tb_melody_player;
   logic clk = 1'b0;
   logic resetn;
   always #10 clk = ~clk;

   melody_player_if if0 ();
   melody_player_if if1 ();
   melody_player_if if2 ();

   logic       st [3];
   logic [2:0] sl [3];
   logic       sp [3];
   logic [9:0] obs [3];

   assign if0.start = st[0];
   assign if0.sel   = sl[0];
   assign if0.stop  = sp[0];
   assign if1.start = st[1];
   assign if1.sel   = sl[1];
   assign if1.stop  = sp[1];
   assign if2.start = st[2];
   assign if2.sel   = sl[2];
   assign if2.stop  = sp[2];
   assign obs[0] = {if0.sound, if0.busy, if0.done, if0.note_idx, if0.step};
   assign obs[1] = {if1.sound, if1.busy, if1.done, if1.note_idx, if1.step};
   assign obs[2] = {if2.sound, if2.busy, if2.done, if2.note_idx, if2.step};

   melody_player #(.NOTE_CYCLES(100), .GAP_CYCLES(10), .OCTAVE_SHIFT(0)) dut0 (
      .CLOCK_50(clk), .resetn(resetn), .bus(if0));
   melody_player #(.NOTE_CYCLES(15000), .GAP_CYCLES(0), .OCTAVE_SHIFT(3)) dut1 (
      .CLOCK_50(clk), .resetn(resetn), .bus(if1));
   melody_player #(.NOTE_CYCLES(100), .GAP_CYCLES(0), .OCTAVE_SHIFT(0)) dut2 (
      .CLOCK_50(clk), .resetn(resetn), .bus(if2));

   bit act  [3];
   int el   [3];
   int msel [3];
   bit dexp [3];
   int checks_total  = 0;
   int checks_passed = 0;

   function automatic int p_note(int i);
      return (i == 1) ? 15000 : 100;
   endfunction

   function automatic int p_gap(int i);
      return (i == 0) ? 10 : 0;
   endfunction

   function automatic int p_shift(int i);
      return (i == 1) ? 3 : 0;
   endfunction

   function automatic int half_tab(int n);
      int t [7];
      t = '{56818, 50607, 47801, 42589, 37936, 35816, 31887};
      return t[n];
   endfunction

   function automatic int rom_note(int m, int k);
      int t [5][8];
      t = '{'{2, 6, 3, 5, 4, 2, 0, 0},
            '{2, 2, 4, 2, 6, 6, 6, 6},
            '{4, 6, 0, 0, 0, 0, 0, 0},
            '{1, 0, 0, 0, 0, 0, 0, 0},
            '{5, 3, 2, 0, 0, 0, 0, 0}};
      return t[m][k];
   endfunction

   function automatic int mel_len(int m);
      int t [5];
      t = '{6, 8, 2, 2, 4};
      return t[m];
   endfunction

   // Position within the melody follows directly from elapsed cycles and slot length.
   function automatic logic [9:0] expected(int i);
      int per, k, o, n, h, snd;
      if (!act[i]) return {2'b00, dexp[i], 7'd0};
      per = p_note(i) + p_gap(i);
      k   = el[i] / per;
      o   = el[i] % per;
      n   = 0;
      snd = 0;
      if (o < p_note(i)) begin
         n   = rom_note(msel[i], k);
         h   = half_tab(n) >> p_shift(i);
         snd = (o / h) % 2;
      end
      return {snd[0], 1'b1, 1'b0, 3'(n), 4'(k)};
   endfunction

   task automatic model_step(int i);
      if (!resetn) begin
         act[i]  = 1'b0;
         dexp[i] = 1'b0;
      end else if (act[i]) begin
         dexp[i] = 1'b0;
         if (sp[i]) begin
            act[i] = 1'b0;
         end else begin
            el[i]++;
            if (el[i] == mel_len(msel[i]) * (p_note(i) + p_gap(i))) begin
               act[i]  = 1'b0;
               dexp[i] = 1'b1;
            end
         end
      end else begin
         dexp[i] = 1'b0;
         if (st[i] && !sp[i] && (sl[i] <= 3'd4)) begin
            act[i]  = 1'b1;
            el[i]   = 0;
            msel[i] = int'(sl[i]);
         end
      end
   endtask

   task automatic check_output(int i);
      logic [9:0] e;
      e = expected(i);
      checks_total++;
      assert (obs[i] === e) begin
         checks_passed++;
      end else begin
         $error("[TB] FAIL outputs%0d t=%0t observed=%b expected=%b (sound,busy,done,note,step)",
                i, $time, obs[i], e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_output(i);
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic apply_stimulus(int i, logic s, logic [2:0] v, logic p);
      st[i] = s;
      sl[i] = v;
      sp[i] = p;
   endtask

   initial begin
      $display("[TB] melody_player bench starting");
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b1, 3'd0, 1'b0);
      run(5);
      for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b0, 3'd0, 1'b0);
      resetn = 1'b1;
      run(10);

      // Correct-letter melody with sel and start wiggled mid-play.
      apply_stimulus(0, 1'b1, 3'd2, 1'b0);
      tick();
      apply_stimulus(0, 1'b0, 3'd0, 1'b0);
      run(100);
      apply_stimulus(0, 1'b1, 3'd4, 1'b0);
      tick();
      apply_stimulus(0, 1'b0, 3'd4, 1'b0);
      run(125);

      apply_stimulus(0, 1'b1, 3'd6, 1'b0);
      run(3);
      apply_stimulus(0, 1'b1, 3'd0, 1'b1);
      run(3);
      apply_stimulus(0, 1'b0, 3'd0, 1'b0);
      run(5);

      // Abort victory at step 3, then abort wrong-letter inside a gap.
      apply_stimulus(0, 1'b1, 3'd1, 1'b0);
      tick();
      apply_stimulus(0, 1'b0, 3'd1, 1'b0);
      run(3 * 110 + 37);
      apply_stimulus(0, 1'b0, 3'd1, 1'b1);
      tick();
      apply_stimulus(0, 1'b0, 3'd1, 1'b0);
      run(900);
      apply_stimulus(0, 1'b1, 3'd3, 1'b0);
      tick();
      apply_stimulus(0, 1'b0, 3'd3, 1'b0);
      run(105);
      apply_stimulus(0, 1'b0, 3'd3, 1'b1);
      tick();
      apply_stimulus(0, 1'b0, 3'd3, 1'b0);
      run(20);

      apply_stimulus(0, 1'b1, 3'd0, 1'b0);
      tick();
      apply_stimulus(0, 1'b0, 3'd0, 1'b0);
      run(200);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      run(700);

      // Gapless lose melody, restarted on its done cycle.
      apply_stimulus(2, 1'b1, 3'd4, 1'b0);
      tick();
      apply_stimulus(2, 1'b0, 3'd4, 1'b0);
      run(400);
      apply_stimulus(2, 1'b1, 3'($urandom_range(0, 4)), 1'b0);
      tick();
      apply_stimulus(2, 1'b0, 3'd0, 1'b0);
      run(900);

      apply_stimulus(1, 1'b1, 3'd3, 1'b0);
      tick();
      apply_stimulus(1, 1'b0, 3'd3, 1'b0);
      run(30010);

      for (int c = 0; c < 6000; c++) begin
         for (int i = 0; i < 3; i++)
            apply_stimulus(i, ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
                           ($urandom_range(0, 599) == 0));
         resetn = ($urandom_range(0, 2999) != 0);
         tick();
      end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b0, 3'd0, 1'b0);
      run(5);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Parametrised tone sequencer driving the passive buzzer.
- On a `start` strobe it plays one of five fixed game melodies: splash, victory, correct letter, wrong letter, lose.
- Each note is a true 50%-duty square wave held for a programmable duration, separated by programmable silent gaps.
- Sits between game control FSM (start/sel/stop) and the buzzer GPIO; reports busy/done so control can sequence screens.

Parameters:
- NOTE_CYCLES, 12500000, clock cycles each note sounds (250 ms at 50 MHz); must be >=1.
- GAP_CYCLES, 1250000, silent clock cycles after each note; 0 = no gap.
- OCTAVE_SHIFT, 0, right-shift applied to every half-period (each +1 raises pitch one octave); legal range 0..3.

Ports:
- CLOCK_50  in  1  50 MHz system clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  request to play melody `sel`; sampled only in IDLE.
- sel  in  3  melody select: 0 splash, 1 victory, 2 correct, 3 wrong, 4 lose, 5-7 invalid.
- stop  in  1  abort playback.
- sound  out  1  square wave to buzzer.
- busy  out  1  high while a melody plays.
- done  out  1  one-cycle pulse on normal completion.
- note_idx  out  3  note currently sounding (0..6); 0 when not in TONE.
- step  out  4  position within melody (0-based); 0 in IDLE.

Behaviour:
- Note half-period table, in cycles before OCTAVE_SHIFT:
  - 0: 56818
  - 1: 50607
  - 2: 47801
  - 3: 42589
  - 4: 37936
  - 5: 35816
  - 6: 31887
- Effective half-period: H = table >> OCTAVE_SHIFT. The half-period counter is 17 bits.
- Melody ROM (note indices, lengths):
  - splash: 2,6,3,5,4,2 (L=6)
  - victory: 2,2,4,2,6,6,6,6 (L=8)
  - correct: 4,6 (L=2)
  - wrong: 1,0 (L=2)
  - lose: 5,3,2,0 (L=4)
- All outputs and state registered. Reset (resetn=0 at a clock edge) takes priority over everything:
  - state=IDLE.
  - sound, busy, done, note_idx, step all 0.
  - All counters 0.
- IDLE:
  - start=1, stop=0, sel<=4: latch sel, step=0, go to TONE.
  - Next cycle: busy=1, note_idx=first note, sound=0, half counter=0, duration counter=0.
  - start with sel 5-7 is ignored; no busy, no done.
- TONE:
  - Half counter increments each cycle; when it equals H-1 it clears and `sound` toggles.
  - First toggle occurs H cycles after TONE entry; the wave then has period 2H.
  - Duration counter runs NOTE_CYCLES cycles, then:
    - GAP_CYCLES>0: go to GAP, sound=0.
    - GAP_CYCLES=0: go straight to next-note handling.
- GAP:
  - sound=0, note_idx=0; lasts GAP_CYCLES cycles, then next-note handling.
- Next-note handling:
  - If step<L-1: step+1, re-enter TONE with phase reset (sound=0, half counter=0).
  - Else: go to IDLE; in that same cycle busy=0 and done=1. done clears on the following cycle.
- Busy duration for melody of length L is exactly L*(NOTE_CYCLES+GAP_CYCLES) cycles.
- A new start is accepted on the cycle done is high (state is IDLE).
- start while busy: ignored; latched sel unaffected; sel changes mid-melody have no effect.
- stop=1 in TONE/GAP: next cycle is IDLE with sound=0, busy=0, step=0, note_idx=0, done=0.
- stop and start together in IDLE: stop wins, nothing starts.
- Reset mid-melody: identical to power-on reset; no done pulse.
- Melody ends with sound=0 regardless of the wave phase at note end.

Test Plan:
- Reset: hold resetn=0 with start=1, sel=0 for 5 cycles -> sound, busy, done, step, note_idx all 0; release -> nothing plays until a new start.
- Sequence (NOTE_CYCLES=100, GAP_CYCLES=10): start with sel=2 -> busy for exactly 220 cycles; note_idx=4 during cycles 1-100, 0 during the gap, 6 during cycles 111-210; step goes 0 then 1; single done pulse as busy falls.
- Pitch (NOTE_CYCLES=200000, OCTAVE_SHIFT=0, sel=3): sound toggles every 50607 cycles during note 1, then every 56818 cycles during note 0; repeat with OCTAVE_SHIFT=1 -> 25303 and 28409.
- Abort: start with sel=1, assert stop at step 3 -> next cycle busy=0, sound=0, step=0, and done never pulses.
- Ignore rules: start with sel=6 -> busy stays 0; start with sel=4 while sel=0 is playing -> splash plays all 6 notes unchanged; start and stop together -> no playback.
- Back-to-back, GAP_CYCLES=0: start with sel=4 -> 4 notes contiguous (5,3,2,0), busy=400 cycles; re-start on the done cycle -> busy rises the next cycle.
